// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback, drives all datapath selects and strobes.
// Latency 3-5 clocks per instruction (branch 3, lw 5); no backpressure, advances one state every clock.
module multicycle_controller #(
  parameter bit EN_BNE          = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalInstr
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWRITE = 4'd4;
  localparam logic [3:0] MEMWB    = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] HALT     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       illegal;
  logic [2:0] alu_funct;
  logic       pc_write;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       illegal_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Every unsupported encoding is caught here so execute states never see one.
  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_JAL: illegal = 1'b0;
      OP_R, OP_I: begin
        case (funct3)
          3'b000, 3'b010, 3'b110, 3'b111: illegal = 1'b0;
          default:                        illegal = 1'b1;
        endcase
      end
      OP_BR: begin
        if (funct3 == 3'b000)                illegal = 1'b0;
        else if (funct3 == 3'b001 && EN_BNE) illegal = 1'b0;
        else                                 illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        if (illegal) begin
          state_nxt = HALT_ON_ILLEGAL ? HALT : FETCH;
        end else begin
          case (op)
            OP_LW, OP_SW: state_nxt = MEMADR;
            OP_R:         state_nxt = EXECUTER;
            OP_I:         state_nxt = EXECUTEI;
            OP_BR:        state_nxt = BRANCH;
            OP_JAL:       state_nxt = JAL;
            default:      state_nxt = FETCH;
          endcase
        end
      end
      MEMADR:                   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:                  state_nxt = MEMWB;
      EXECUTER, EXECUTEI, JAL:  state_nxt = ALUWB;
      MEMWB, MEMWRITE, ALUWB:   state_nxt = FETCH;
      BRANCH:                   state_nxt = FETCH;
      HALT:                     state_nxt = HALT;
      default:                  state_nxt = FETCH;
    endcase
  end

  // op[5] separates R-type from I-type, so addi with instr[30] set still adds.
  always_comb begin
    alu_funct = 3'b000;
    case (funct3)
      3'b000:  alu_funct = (op[5] && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_funct = 3'b101;
      3'b110:  alu_funct = 3'b011;
      3'b111:  alu_funct = 3'b010;
      default: alu_funct = 3'b000;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    illegal_flag = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUControl   = 3'b000;
    case (state)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b01;
        illegal_flag = illegal;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_funct;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_funct;
      end
      ALUWB: reg_write = 1'b1;
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_write   = funct3[0] ? ~Zero : Zero;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
      end
      HALT: illegal_flag = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Reset gates strobes combinationally so nothing writes in the reset delta.
  assign PCWrite      = pc_write     & ~reset;
  assign MemWrite     = mem_write    & ~reset;
  assign IRWrite      = ir_write     & ~reset;
  assign RegWrite     = reg_write    & ~reset;
  assign IllegalInstr = illegal_flag & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: dut0 (bne on, no halt) and dut1 (bne off, halt on illegal).
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int PH_RST = 0, PH_FETCH = 1, PH_DEC = 2, PH_DEC_ILL = 3, PH_MADR = 4, PH_MRD = 5,
                 PH_MWR = 6, PH_MWB = 7, PH_EXR = 8, PH_EXI = 9, PH_AWB = 10, PH_BR = 11,
                 PH_JAL = 12, PH_HALT = 13;

  typedef struct {
    int          ph;
    logic [16:0] exp;
    logic [16:0] care;
    int          pcw_mode;
    bit          halt_after;
  } rec_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero;

  logic pcw0, adr0, mw0, irw0, rw0, ill0;
  logic [1:0] rs0, sa0, sb0, imm0;
  logic [2:0] alu0;
  logic pcw1, adr1, mw1, irw1, rw1, ill1;
  logic [1:0] rs1, sa1, sb1, imm1;
  logic [2:0] alu1;
  logic [16:0] act0, act1;

  int passed = 0;
  int total  = 0;
  rec_t seq [2][8];
  int len [2];
  int pos [2];
  bit halted [2];

  always #5 clk = ~clk;

  multicycle_controller #(.EN_BNE(1'b1), .HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .ResultSrc(rs0),
    .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUControl(alu0), .ImmSrc(imm0), .RegWrite(rw0),
    .IllegalInstr(ill0));

  multicycle_controller #(.EN_BNE(1'b0), .HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .ResultSrc(rs1),
    .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(alu1), .ImmSrc(imm1), .RegWrite(rw1),
    .IllegalInstr(ill1));

  assign act0 = {pcw0, adr0, mw0, irw0, rs0, sa0, sb0, alu0, imm0, rw0, ill0};
  assign act1 = {pcw1, adr1, mw1, irw1, rs1, sa1, sb1, alu1, imm1, rw1, ill1};

  function automatic string phname(input int ph);
    case (ph)
      PH_RST: return "reset";       PH_FETCH: return "fetch";    PH_DEC: return "decode";
      PH_DEC_ILL: return "decode_ill"; PH_MADR: return "memadr"; PH_MRD: return "memread";
      PH_MWR: return "memwrite";    PH_MWB: return "memwb";      PH_EXR: return "executer";
      PH_EXI: return "executei";    PH_AWB: return "aluwb";      PH_BR: return "branch";
      PH_JAL: return "jal";         default: return "halt";
    endcase
  endfunction

  function automatic logic [1:0] imm_exp(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BR)  return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f3, input bit en_bne);
    if (o == OP_LW || o == OP_SW || o == OP_JAL) return 1'b1;
    if (o == OP_R || o == OP_I) return (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
    if (o == OP_BR) return (f3 == 3'd0 || (en_bne && f3 == 3'd1));
    return 1'b0;
  endfunction

  function automatic logic [2:0] alu_exp(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o == OP_R && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle of a phase; care bits mark the fields the phase defines.
  function automatic rec_t mk(input int ph, input logic [2:0] al_in);
    rec_t r;
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0;
    logic [2:0] al = 0;
    bit ca = 0, cr = 0, csa = 0, csb = 0, cal = 0;
    case (ph)
      PH_RST, PH_FETCH: begin
        pcw = (ph == PH_FETCH); irw = (ph == PH_FETCH); rs = 2'b10; sb = 2'b10;
        ca = 1; cr = 1; csa = 1; csb = 1; cal = 1;
      end
      PH_DEC, PH_DEC_ILL: begin sa = 2'b01; sb = 2'b01; ill = (ph == PH_DEC_ILL); csa = 1; csb = 1; cal = 1; end
      PH_MADR: begin sa = 2'b10; sb = 2'b01; csa = 1; csb = 1; cal = 1; end
      PH_MRD:  begin adr = 1; ca = 1; cr = 1; end
      PH_MWR:  begin adr = 1; mw = 1; ca = 1; cr = 1; end
      PH_MWB:  begin rs = 2'b01; rw = 1; cr = 1; end
      PH_EXR:  begin sa = 2'b10; sb = 2'b00; al = al_in; csa = 1; csb = 1; cal = 1; end
      PH_EXI:  begin sa = 2'b10; sb = 2'b01; al = al_in; csa = 1; csb = 1; cal = 1; end
      PH_AWB:  begin rw = 1; cr = 1; end
      PH_BR:   begin sa = 2'b10; al = 3'b001; csa = 1; csb = 1; cal = 1; cr = 1; end
      PH_JAL:  begin sa = 2'b01; sb = 2'b10; pcw = 1; csa = 1; csb = 1; cal = 1; cr = 1; end
      default: ill = 1;
    endcase
    r.ph = ph; r.pcw_mode = 0; r.halt_after = 0;
    r.exp  = {pcw, adr, mw, irw, rs, sa, sb, al, 2'b00, rw, ill};
    r.care = {1'b1, ca, 1'b1, 1'b1, {2{cr}}, {2{csa}}, {2{csb}}, {3{cal}}, 2'b11, 1'b1, 1'b1};
    return r;
  endfunction

  task automatic push(input int k, input rec_t r);
    seq[k][len[k]] = r;
    len[k] = len[k] + 1;
  endtask

  // Whole-instruction expectation built at FETCH from the instruction fields.
  task automatic build(input int k);
    rec_t r;
    logic [2:0] a;
    a = alu_exp(op, funct3, funct7b5);
    len[k] = 0; pos[k] = 0;
    push(k, mk(PH_FETCH, 3'b0));
    if (!legal(op, funct3, k == 0)) begin
      r = mk(PH_DEC_ILL, 3'b0);
      r.halt_after = (k == 1);
      push(k, r);
    end else begin
      push(k, mk(PH_DEC, 3'b0));
      case (op)
        OP_LW:  begin push(k, mk(PH_MADR, 3'b0)); push(k, mk(PH_MRD, 3'b0)); push(k, mk(PH_MWB, 3'b0)); end
        OP_SW:  begin push(k, mk(PH_MADR, 3'b0)); push(k, mk(PH_MWR, 3'b0)); end
        OP_R:   begin push(k, mk(PH_EXR, a)); push(k, mk(PH_AWB, 3'b0)); end
        OP_I:   begin push(k, mk(PH_EXI, a)); push(k, mk(PH_AWB, 3'b0)); end
        OP_BR:  begin r = mk(PH_BR, 3'b0); r.pcw_mode = funct3[0] ? 2 : 1; push(k, r); end
        OP_JAL: begin push(k, mk(PH_JAL, 3'b0)); push(k, mk(PH_AWB, 3'b0)); end
        default: ;
      endcase
    end
  endtask

  task automatic compare_one(input int k);
    rec_t r;
    logic [16:0] act, e;
    logic rk;
    act = (k == 0) ? act0 : act1;
    rk  = (k == 0) ? rst0 : rst1;
    if (rk) begin
      len[k] = 0; pos[k] = 0; halted[k] = 0;
      r = mk(PH_RST, 3'b0);
    end else if (halted[k]) begin
      r = mk(PH_HALT, 3'b0);
    end else begin
      if (pos[k] >= len[k]) build(k);
      r = seq[k][pos[k]];
    end
    e = r.exp;
    e[3:2] = imm_exp(op);
    if (r.pcw_mode == 1) e[16] = Zero;
    else if (r.pcw_mode == 2) e[16] = ~Zero;
    total++;
    if ((act & r.care) === (e & r.care)) passed++;
    else $display("FAIL model dut%0d %s: got %b want %b care %b", k, phname(r.ph), act, e, r.care);
  endtask

  task automatic advance(input int k);
    logic rk;
    rk = (k == 0) ? rst0 : rst1;
    if (rk) begin
      len[k] = 0; pos[k] = 0; halted[k] = 0;
    end else if (!halted[k] && pos[k] < len[k]) begin
      if (seq[k][pos[k]].halt_after) halted[k] = 1;
      pos[k] = pos[k] + 1;
    end
  endtask

  initial begin
    len[0] = 0; len[1] = 0; pos[0] = 0; pos[1] = 0; halted[0] = 0; halted[1] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) compare_one(k);
      @(posedge clk);
      for (int k = 0; k < 2; k++) advance(k);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  // Starts in a FETCH cycle; returns in the next FETCH cycle (bounded).
  task automatic run_instr(input int k, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int exp_n, input int probe_n,
                           input logic [16:0] pmask, input logic [16:0] pval, input string nm);
    logic [16:0] a;
    int n;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      a = (k == 0) ? act0 : act1;
      if (n == probe_n) chk({nm, "_probe"}, {15'd0, a & pmask}, {15'd0, pval});
      if (a[13]) break;
    end
    chk({nm, "_cycles"}, n, exp_n);
  endtask

  task automatic halt_case(input logic [6:0] o, input logic [2:0] f3, input string nm);
    op = o; funct3 = f3; funct7b5 = 1'b0; Zero = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_decode_ill"}, {31'd0, act1[0]}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_halt"}, {15'd0, act1 & 17'h16003}, 32'h1);
    rst1 = 1'b1; #1;
    chk({nm, "_reset"}, {15'd0, act1 & 17'h16003}, 32'h0);
    @(posedge clk); #1;
    rst1 = 1'b0; #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    op = OP_LW; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
    @(posedge clk); #1;
    chk("reset_strobes_dut0", {27'd0, pcw0, mw0, irw0, rw0, ill0}, 32'h0);
    chk("reset_strobes_dut1", {27'd0, pcw1, mw1, irw1, rw1, ill1}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst0 = 1'b0; #1;
    chk("first_fetch", {29'd0, pcw0, irw0, adr0}, 32'b110);

    run_instr(0, OP_LW, 3'd2, 1'b0, 1'b0, 5, 4, 17'h01802, 17'h00802, "lw");
    run_instr(0, OP_SW, 3'd2, 1'b0, 1'b0, 4, 3, 17'h0C002, 17'h0C000, "sw");
    run_instr(0, OP_R,  3'd0, 1'b1, 1'b0, 4, 2, 17'h00070, 17'h00010, "sub");
    run_instr(0, OP_R,  3'd0, 1'b0, 1'b0, 4, 2, 17'h00070, 17'h00000, "add");
    run_instr(0, OP_I,  3'd0, 1'b1, 1'b0, 4, 2, 17'h00070, 17'h00000, "addi_f7");
    run_instr(0, OP_R,  3'd2, 1'b0, 1'b0, 4, 2, 17'h00070, 17'h00050, "slt");
    run_instr(0, OP_R,  3'd6, 1'b0, 1'b0, 4, 2, 17'h00070, 17'h00030, "or");
    run_instr(0, OP_I,  3'd7, 1'b0, 1'b0, 4, 2, 17'h00070, 17'h00020, "andi");
    run_instr(0, OP_BR, 3'd0, 1'b0, 1'b1, 3, 2, 17'h10000, 17'h10000, "beq_taken");
    run_instr(0, OP_BR, 3'd0, 1'b0, 1'b0, 3, 2, 17'h10000, 17'h00000, "beq_not");
    run_instr(0, OP_BR, 3'd1, 1'b0, 1'b1, 3, 2, 17'h10000, 17'h00000, "bne_not");
    run_instr(0, OP_BR, 3'd1, 1'b0, 1'b0, 3, 2, 17'h10000, 17'h10000, "bne_taken");
    run_instr(0, OP_JAL, 3'd0, 1'b0, 1'b0, 4, 2, 17'h10600, 17'h10200, "jal");
    run_instr(0, 7'b1111111, 3'd0, 1'b0, 1'b0, 2, 1, 17'h00001, 17'h00001, "illegal_op");
    run_instr(0, OP_BR, 3'd4, 1'b0, 1'b0, 2, 1, 17'h00001, 17'h00001, "illegal_br");
    run_instr(0, OP_I,  3'd1, 1'b0, 1'b0, 2, 1, 17'h00001, 17'h00001, "illegal_alu");

    // Asynchronous reset in the middle of a store.
    op = OP_SW; funct3 = 3'd2; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sw_memwrite", {31'd0, mw0}, 32'd1);
    #2; rst0 = 1'b1; #1;
    chk("midreset_strobes", {15'd0, act0 & 17'h16003}, 32'h0);
    @(posedge clk); #1;
    rst0 = 1'b0; #1;
    run_instr(0, OP_LW, 3'd2, 1'b0, 1'b0, 5, 3, 17'h08000, 17'h08000, "lw_after_reset");

    rst0 = 1'b1; rst1 = 1'b0; #1;
    run_instr(1, OP_LW, 3'd2, 1'b0, 1'b0, 5, 3, 17'h0C000, 17'h08000, "d1_lw");
    run_instr(1, OP_BR, 3'd0, 1'b0, 1'b1, 3, 2, 17'h10000, 17'h10000, "d1_beq");
    halt_case(OP_BR, 3'd1, "d1_bne");
    run_instr(1, OP_JAL, 3'd0, 1'b0, 1'b0, 4, 2, 17'h10000, 17'h10000, "d1_jal");
    halt_case(7'b1111111, 3'd0, "d1_badop");
    run_instr(1, OP_SW, 3'd2, 1'b0, 1'b0, 4, 3, 17'h04000, 17'h04000, "d1_sw");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
